// File: rtl/clkdv_bcd_counter_pkg.sv
// Shared BCD types and constants for consumers of the divided clock CLKDV.
// Default terminal value is 59 (minutes/seconds display).
package clkdv_bcd_counter_pkg;

    localparam int BCD_W        = 4;
    localparam int DEF_MAX_TENS = 5;
    localparam int DEF_MAX_ONES = 9;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd2_t;

    function automatic logic bcd_valid(input bcd2_t v);
        return (v.tens <= BCD_MAX) && (v.ones <= BCD_MAX);
    endfunction

    // Digit-wise magnitude compare; both operands are assumed to be valid BCD.
    function automatic logic bcd_gt(input bcd2_t a, input bcd2_t b);
        return (a.tens > b.tens) || ((a.tens == b.tens) && (a.ones > b.ones));
    endfunction

endpackage

// File: rtl/clkdv_sync_edge.sv
// Synchronises an asynchronous level (CLKDV) and emits a registered one-cycle tick per rising edge.
// Latency: rise to tick high in SYNC_STAGES+1 clk edges; no backpressure (free-running enable).
module clkdv_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clkdv,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   prev;
    logic                   armed;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // The chain resets to 0, so a CLKDV already high at release would look like a rise.
    // Arming waits until the chain holds real samples and prev has seen one of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            fill  <= '0;
            prev  <= 1'b0;
            armed <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], clkdv};
            fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev  <= s;
            armed <= fill[SYNC_STAGES-1];
            tick  <= s & ~prev & armed;
        end
    end

endmodule

// File: rtl/clkdv_bcd_counter.sv
// Two-digit BCD modulo counter (00..MAX_TENS:MAX_ONES) advanced by ticks derived from CLKDV edges.
// Latency: digits/TC update on the edge after TICK or with LOAD; no backpressure, counts every enabled tick.
module clkdv_bcd_counter
    import clkdv_bcd_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_TENS    = DEF_MAX_TENS,
    parameter int MAX_ONES    = DEF_MAX_ONES
) (
    input  logic             CLKIN,
    input  logic             RESETN,
    input  logic             CLKDV,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [BCD_W-1:0] LD_TENS,
    input  logic [BCD_W-1:0] LD_ONES,
    output logic             TICK,
    output logic [BCD_W-1:0] TENS,
    output logic [BCD_W-1:0] ONES,
    output logic             TC
);

    localparam bcd2_t MAX_CNT  = {BCD_W'(MAX_TENS), BCD_W'(MAX_ONES)};
    localparam bcd2_t ZERO_CNT = '0;

    bcd2_t cnt;
    bcd2_t cnt_nxt;
    bcd2_t ld_val;
    logic  tc_nxt;

    clkdv_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (CLKIN),
        .rst_n(RESETN),
        .clkdv(CLKDV),
        .tick (TICK)
    );

    assign ld_val = {LD_TENS, LD_ONES};

    // LOAD wins over a coincident tick; the tick is simply lost.
    always_comb begin
        cnt_nxt = cnt;
        tc_nxt  = 1'b0;
        if (LOAD) begin
            if (!bcd_valid(ld_val) || bcd_gt(ld_val, MAX_CNT)) begin
                cnt_nxt = MAX_CNT;
            end else begin
                cnt_nxt = ld_val;
            end
        end else if (TICK && EN) begin
            if (UP) begin
                if (cnt == MAX_CNT) begin
                    cnt_nxt = ZERO_CNT;
                    tc_nxt  = 1'b1;
                end else if (cnt.ones == BCD_MAX) begin
                    cnt_nxt.ones = '0;
                    cnt_nxt.tens = cnt.tens + 4'd1;
                end else begin
                    cnt_nxt.ones = cnt.ones + 4'd1;
                end
            end else begin
                if (cnt == ZERO_CNT) begin
                    cnt_nxt = MAX_CNT;
                    tc_nxt  = 1'b1;
                end else if (cnt.ones == '0) begin
                    cnt_nxt.ones = BCD_MAX;
                    cnt_nxt.tens = cnt.tens - 4'd1;
                end else begin
                    cnt_nxt.ones = cnt.ones - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            cnt <= ZERO_CNT;
            TC  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            TC  <= tc_nxt;
        end
    end

    assign TENS = cnt.tens;
    assign ONES = cnt.ones;

endmodule
